// File: rtl/apb_secure_pkg.sv
// Shared types and helpers for the APB security gate.
package apb_secure_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } sec_state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } txn_state_e;

  // Bits needed to hold a counter running from 0 to n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_secure_gate_if.sv
// Upstream and downstream APB signals of the security gate.
interface apb_secure_gate_if #(
  parameter int NSLV = 4,
  parameter int AW   = 20,
  parameter int DW   = 16
);
  logic [NSLV-1:0]    psel_s;
  logic               penable_s;
  logic               pwrite_s;
  logic [DW/8-1:0]    pstrb_s;
  logic [AW-1:0]      paddr_s;
  logic [DW-1:0]      pwdata_s;
  logic [DW-1:0]      prdata_s;
  logic               pready_s;
  logic               pslverr_s;

  logic [NSLV-1:0]    psel;
  logic               penable;
  logic               pwrite;
  logic [DW/8-1:0]    pstrb;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [NSLV*DW-1:0] prdata_m;
  logic [NSLV-1:0]    pready_m;
  logic [NSLV-1:0]    pslverr_m;

  // Gate view: completer towards the requester, requester towards the completers.
  modport slave (
    input  psel_s, penable_s, pwrite_s, pstrb_s, paddr_s, pwdata_s,
    output prdata_s, pready_s, pslverr_s,
    output psel, penable, pwrite, pstrb, paddr, pwdata,
    input  prdata_m, pready_m, pslverr_m
  );

  // Environment view: upstream requester plus downstream completers.
  modport master (
    output psel_s, penable_s, pwrite_s, pstrb_s, paddr_s, pwdata_s,
    input  prdata_s, pready_s, pslverr_s,
    input  psel, penable, pwrite, pstrb, paddr, pwdata,
    output prdata_m, pready_m, pslverr_m
  );
endinterface

// File: rtl/apb_secure_ctrl.sv
// Security state machine: lock/unlock, consecutive-failure lockout, idle relock.
module apb_secure_ctrl
  import apb_secure_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 4096,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic good_pw,
  input  logic bad_pw,
  input  logic prot_access,
  input  logic busy,
  output logic unlocked_eff,
  output logic in_lockout,
  output logic locked,
  output logic lockout
);

  localparam int FW = cnt_w(MAX_FAIL);
  localparam int LW = cnt_w(LOCKOUT_CYC);
  localparam int IW = cnt_w((TIMEOUT > 0) ? TIMEOUT : 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  sec_state_e    sec_q;
  logic [FW-1:0] fail_q;
  logic [LW-1:0] lock_cnt_q;
  logic [IW-1:0] idle_q;
  logic          locked_q;
  logic          lockout_q;
  logic          timeout_hit;

  // The idle timer expires on this edge; a request sampled now must see LOCKED.
  assign timeout_hit  = (TIMEOUT != 0) && (sec_q == UNLOCKED) && !busy &&
                        (idle_q == IDLE_LAST);
  assign unlocked_eff = (sec_q == UNLOCKED) && !timeout_hit;
  assign in_lockout   = (sec_q == LOCKOUT);
  assign locked       = locked_q;
  assign lockout      = lockout_q;

  // Security FSM with its fail, lockout and idle counters and registered status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_q      <= LOCKED;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      idle_q     <= '0;
      locked_q   <= 1'b1;
      lockout_q  <= 1'b0;
    end else begin
      case (sec_q)
        LOCKED, UNLOCKED: begin
          if (good_pw) begin
            sec_q    <= (sec_q == LOCKED) ? UNLOCKED : LOCKED;
            locked_q <= (sec_q == UNLOCKED);
            fail_q   <= '0;
            idle_q   <= '0;
          end else if (bad_pw) begin
            if (fail_q == FAIL_LAST) begin
              sec_q      <= LOCKOUT;
              locked_q   <= 1'b1;
              lockout_q  <= 1'b1;
              fail_q     <= '0;
              lock_cnt_q <= '0;
            end else begin
              fail_q <= fail_q + FW'(1);
            end
          end else if (sec_q == UNLOCKED) begin
            if (timeout_hit) begin
              sec_q    <= LOCKED;
              locked_q <= 1'b1;
              idle_q   <= '0;
            end else if (prot_access) begin
              idle_q <= '0;
            end else if (!busy && (TIMEOUT != 0)) begin
              idle_q <= idle_q + IW'(1);
            end
          end
        end
        LOCKOUT: begin
          if (lock_cnt_q == LOCK_LAST) begin
            sec_q      <= LOCKED;
            lockout_q  <= 1'b0;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LW'(1);
          end
        end
        default: begin
          sec_q     <= LOCKED;
          locked_q  <= 1'b1;
          lockout_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_secure_gate.sv
// APB security gate: forwards open lines always, protected lines only when unlocked,
// and answers password writes and status reads locally.
module apb_secure_gate
  import apb_secure_pkg::*;
#(
  parameter int              NSLV        = 4,
  parameter int              AW          = 20,
  parameter int              DW          = 16,
  parameter logic [AW-1:0]   PAS_ADR     = 20'h00C1A,
  parameter logic [DW-1:0]   PAS_DATA    = 16'hA007,
  parameter logic [NSLV-1:0] OPEN_MASK   = 4'b0001,
  parameter int              MAX_FAIL    = 3,
  parameter int              LOCKOUT_CYC = 4096,
  parameter int              TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  apb_secure_gate_if.slave bus,
  output logic             locked,
  output logic             lockout
);

  txn_state_e        txn_q;
  logic [NSLV-1:0]   psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [DW/8-1:0]   pstrb_q;
  logic [AW-1:0]     paddr_q;
  logic [DW-1:0]     pwdata_q;
  logic [DW-1:0]     prdata_s_q;
  logic              pready_s_q;
  logic              pslverr_s_q;
  logic              pend_good_q;
  logic              pend_bad_q;

  logic              unlocked_eff, in_lockout;
  logic              sample, onehot, open_hit, pas_hit, pw_wr, st_rd, pw_ok, fwd;
  logic              prot_access, good_pw, bad_pw, busy;
  logic [DW-1:0]     status_word;
  logic              sel_ready, sel_err;
  logic [DW-1:0]     sel_rdata;

  // Classify the request presented upstream against the current security state.
  always_comb begin
    sample      = (txn_q == IDLE) && (bus.psel_s != '0) && bus.penable_s;
    onehot      = $onehot(bus.psel_s);
    open_hit    = (bus.psel_s & OPEN_MASK) != '0;
    pas_hit     = onehot && !open_hit && (bus.paddr_s == PAS_ADR);
    pw_wr       = pas_hit && bus.pwrite_s;
    st_rd       = pas_hit && !bus.pwrite_s;
    pw_ok       = (bus.pwdata_s == PAS_DATA) && (&bus.pstrb_s);
    fwd         = onehot && !pas_hit && (open_hit || unlocked_eff);
    prot_access = sample && fwd && !open_hit;
    status_word    = '0;
    status_word[1] = in_lockout;
    status_word[0] = ~unlocked_eff;
  end

  // Pick ready/error/data of the completer currently selected downstream.
  always_comb begin
    sel_ready = |(bus.pready_m & psel_q);
    sel_err   = |(bus.pslverr_m & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | bus.prdata_m[i*DW +: DW];
    end
  end

  // Password outcomes land when the response cycle ends, so the state changes after pready_s.
  assign good_pw = (txn_q == RESP) && pend_good_q;
  assign bad_pw  = (txn_q == RESP) && pend_bad_q;
  assign busy    = (txn_q != IDLE);

  // Transaction FSM with registered upstream and downstream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_q       <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      prdata_s_q  <= '0;
      pready_s_q  <= 1'b0;
      pslverr_s_q <= 1'b0;
      pend_good_q <= 1'b0;
      pend_bad_q  <= 1'b0;
    end else begin
      case (txn_q)
        IDLE: begin
          if (sample) begin
            pend_good_q <= 1'b0;
            pend_bad_q  <= 1'b0;
            if (fwd) begin
              txn_q    <= SETUP;
              psel_q   <= bus.psel_s;
              pwrite_q <= bus.pwrite_s;
              pstrb_q  <= bus.pstrb_s;
              paddr_q  <= bus.paddr_s;
              pwdata_q <= bus.pwdata_s;
            end else begin
              txn_q       <= RESP;
              pready_s_q  <= 1'b1;
              prdata_s_q  <= '0;
              pslverr_s_q <= 1'b1;
              if (st_rd) begin
                prdata_s_q  <= status_word;
                pslverr_s_q <= 1'b0;
              end else if (pw_wr && !in_lockout) begin
                if (pw_ok) begin
                  pslverr_s_q <= 1'b0;
                  pend_good_q <= 1'b1;
                end else begin
                  pend_bad_q <= 1'b1;
                end
              end
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          txn_q     <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pready_s_q  <= 1'b1;
            prdata_s_q  <= sel_rdata;
            pslverr_s_q <= sel_err;
            txn_q       <= RESP;
          end
        end
        RESP: begin
          pready_s_q  <= 1'b0;
          pslverr_s_q <= 1'b0;
          prdata_s_q  <= '0;
          pend_good_q <= 1'b0;
          pend_bad_q  <= 1'b0;
          txn_q       <= IDLE;
        end
        default: txn_q <= IDLE;
      endcase
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.prdata_s  = prdata_s_q;
  assign bus.pready_s  = pready_s_q;
  assign bus.pslverr_s = pslverr_s_q;

  apb_secure_ctrl #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT_CYC (LOCKOUT_CYC),
    .TIMEOUT     (TIMEOUT)
  ) u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .good_pw      (good_pw),
    .bad_pw       (bad_pw),
    .prot_access  (prot_access),
    .busy         (busy),
    .unlocked_eff (unlocked_eff),
    .in_lockout   (in_lockout),
    .locked       (locked),
    .lockout      (lockout)
  );

endmodule
